// File: rtl/sd_pkg.sv
// Shared definitions for the SD DAT-line writer.
//   state_t     : writer FSM state encoding
//   ACCEPTED .. : CRC-status tokens returned by the card on DAT0
//                 (TIMEOUT is a local code that no card ever sends)
//   CRC16_POLY  : x^16 + x^12 + x^5 + 1 with the x^16 term implied
package sd_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_PRE,
    ST_START,
    ST_DATA,
    ST_CRC,
    ST_END,
    ST_STAT,
    ST_BUSY,
    ST_FIN
  } state_t;

  localparam logic [2:0] ACCEPTED = 3'b010;
  localparam logic [2:0] CRC_ERR  = 3'b101;
  localparam logic [2:0] WR_ERR   = 3'b110;
  localparam logic [2:0] TIMEOUT  = 3'b111;

  localparam logic [15:0] CRC16_POLY = 16'h1021;

endpackage

// File: rtl/sd_crc16.sv
// Bit-serial CRC16 for one SD DAT line, MSB-first, initial value 0.
//   clk : system clock
//   rst : synchronous active-high reset
//   clr : synchronous clear back to 0
//   en  : advance the CRC by one bit
//   din : data bit on this line
//   crc : current remainder
module sd_crc16
  import sd_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        en,
  input  logic        din,
  output logic [15:0] crc
);

  logic fb;

  assign fb = din ^ crc[15];

  // NOTE: clocked state uses non-blocking (<=) so every flop samples the
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      crc <= '0;
    end else if (en) begin
      crc <= {crc[14:0], 1'b0} ^ (fb ? CRC16_POLY : 16'h0000);
    end
  end

endmodule

// File: rtl/sd_dat_writer.sv
// Host-side SD DAT[3:0] transmitter for one 512-byte single-block write
// in 4-bit mode: preamble, start bit, 1024 nibbles, per-line CRC16, end
// bit, then CRC-status token decode on DAT0 and busy wait.
//
// Optional feature macro: SD_DAT_WRITER_BUSY_TIMEOUT_EN -- when defined the
// busy wait aborts after BUSY_TIMEOUT rises (status 3'b111); otherwise the
// busy wait is unbounded and no busy counter exists.
//
// Ports:
//   clk, rst           : system clock, synchronous active-high reset
//   sdclk              : SD clock, edge-detected as data in clk
//   sddat_in/out/oe    : DAT pad readback, drive value, output enable
//   wstart/wbusy       : start pulse / transfer in progress
//   wdone/werr/wstat   : completion pulse, error flag, last status token
//   inreq/inaddr/inbyte: byte fetch; inbyte is sampled 1 clk after inreq
module sd_dat_writer
  import sd_pkg::*;
#(
  parameter int PRE_CYCLES   = 8,
  parameter int STAT_TIMEOUT = 64,
  parameter int BUSY_TIMEOUT = 1000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sdclk,
  input  logic [3:0] sddat_in,
  output logic [3:0] sddat_out,
  output logic       sddat_oe,
  input  logic       wstart,
  output logic       wbusy,
  output logic       wdone,
  output logic       werr,
  output logic [2:0] wstat,
  output logic       inreq,
  output logic [8:0] inaddr,
  input  logic [7:0] inbyte
);

  localparam int TMO_W = $clog2(STAT_TIMEOUT + 1);

  localparam bit PARAMS_OK = (PRE_CYCLES >= 1) && (PRE_CYCLES <= 255) &&
                             (STAT_TIMEOUT >= 1) && (BUSY_TIMEOUT >= 1) &&
                             (BUSY_TIMEOUT <= (1 << 20));
  if (!PARAMS_OK) begin : g_bad_params
    $error("sd_dat_writer: parameter out of range");
  end

  state_t          state, state_d;
  logic            sdclkl;
  logic            rise, fall;
  logic [9:0]      cnt;        // preamble, nibble and CRC bit counter
  logic [TMO_W-1:0] tmo_cnt;   // rises spent waiting for the status start bit
  logic [2:0]      bit_cnt;    // 0: hunting start bit, 1..3: token, 4: end bit
  logic [2:0]      stat_sh;
  logic [7:0]      pre_byte;   // prefetched byte; high nibble goes out first
  logic [3:0]      lo_nib;
  logic            req_q;
  logic [3:0]      nib;
  logic [3:0]      crc_bit_idx;
  logic [3:0]      crc_nib;
  logic            start_bit;
  logic            tmo_exit;
  logic            dat_en;
  logic [15:0]     crc [4];
  logic            unused_dat;

  assign rise = ~sdclkl & sdclk;
  assign fall = sdclkl & ~sdclk;

  // Status only travels on DAT0; the upper lines are just pulled up.
  assign unused_dat = ^sddat_in[3:1];

  // A low DAT0 only counts once we have stopped driving the pads.
  assign start_bit = ~sddat_in[0] & ~sddat_oe;

  assign nib         = cnt[0] ? lo_nib : pre_byte[7:4];
  assign crc_bit_idx = 4'd15 - cnt[3:0];
  assign crc_nib     = {crc[3][crc_bit_idx], crc[2][crc_bit_idx],
                        crc[1][crc_bit_idx], crc[0][crc_bit_idx]};
  assign dat_en      = fall && (state == ST_DATA);

  assign wbusy = (state != ST_IDLE);
  assign wdone = (state == ST_FIN);

  for (genvar i = 0; i < 4; i++) begin : g_crc
    sd_crc16 u_crc (
      .clk (clk),
      .rst (rst),
      .clr (state == ST_IDLE),
      .en  (dat_en),
      .din (nib[i]),
      .crc (crc[i])
    );
  end

`ifdef SD_DAT_WRITER_BUSY_TIMEOUT_EN
  logic [19:0] busy_cnt;

  always_ff @(posedge clk) begin
    if (rst || state != ST_BUSY) begin
      busy_cnt <= '0;
    end else if (rise) begin
      busy_cnt <= busy_cnt + 20'd1;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_d;
    end
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave a value unassigned and infer a latch.
  always_comb begin
    state_d  = state;
    tmo_exit = 1'b0;
    unique case (state)
      ST_IDLE:  if (wstart) state_d = ST_PRE;
      ST_PRE:   if (fall && cnt == 10'(PRE_CYCLES - 1)) state_d = ST_START;
      ST_START: if (fall) state_d = ST_DATA;
      ST_DATA:  if (fall && cnt == 10'd1023) state_d = ST_CRC;
      ST_CRC:   if (fall && cnt == 10'd15) state_d = ST_END;
      ST_END:   if (fall) state_d = ST_STAT;
      ST_STAT: begin
        if (rise) begin
          if (bit_cnt == 3'd4) begin
            state_d = ST_BUSY;
          end else if (bit_cnt == 3'd0 && !start_bit &&
                       tmo_cnt == TMO_W'(STAT_TIMEOUT - 1)) begin
            state_d  = ST_FIN;
            tmo_exit = 1'b1;
          end
        end
      end
      ST_BUSY: begin
        if (rise) begin
          if (sddat_in[0]) begin
            state_d = ST_FIN;
`ifdef SD_DAT_WRITER_BUSY_TIMEOUT_EN
          end else if (busy_cnt == 20'(BUSY_TIMEOUT - 1)) begin
            state_d  = ST_FIN;
            tmo_exit = 1'b1;
`endif
          end
        end
      end
      ST_FIN:   state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sdclkl    <= 1'b0;
      sddat_out <= 4'hF;
      sddat_oe  <= 1'b0;
      werr      <= 1'b0;
      wstat     <= 3'b000;
      inreq     <= 1'b0;
      inaddr    <= '0;
      cnt       <= '0;
      tmo_cnt   <= '0;
      bit_cnt   <= '0;
      stat_sh   <= '0;
      pre_byte  <= '0;
      lo_nib    <= '0;
      req_q     <= 1'b0;
    end else begin
      sdclkl <= sdclk;
      inreq  <= 1'b0;
      req_q  <= inreq;
      if (req_q) pre_byte <= inbyte;

      unique case (state)
        ST_IDLE, ST_FIN: begin
          sddat_oe  <= 1'b0;
          sddat_out <= 4'hF;
          cnt       <= '0;
          if (state == ST_IDLE && wstart) begin
            inreq  <= 1'b1;
            inaddr <= '0;
          end
        end
        ST_PRE: begin
          if (fall) begin
            sddat_oe  <= 1'b1;
            sddat_out <= 4'hF;
            cnt <= (cnt == 10'(PRE_CYCLES - 1)) ? 10'd0 : cnt + 10'd1;
          end
        end
        ST_START: if (fall) sddat_out <= 4'h0;
        ST_DATA: begin
          if (fall) begin
            sddat_out <= nib;
            // The high-nibble fall of byte N fetches byte N+1 into the
            // now-free prefetch register; the low nibble is parked first.
            if (!cnt[0]) begin
              lo_nib <= pre_byte[3:0];
              if (cnt[9:1] != 9'd511) begin
                inreq  <= 1'b1;
                inaddr <= cnt[9:1] + 9'd1;
              end
            end
            cnt <= (cnt == 10'd1023) ? 10'd0 : cnt + 10'd1;
          end
        end
        ST_CRC: begin
          if (fall) begin
            sddat_out <= crc_nib;
            cnt <= (cnt == 10'd15) ? 10'd0 : cnt + 10'd1;
          end
        end
        ST_END: begin
          if (fall) sddat_out <= 4'hF;
          tmo_cnt <= '0;
          bit_cnt <= '0;
          stat_sh <= '0;
        end
        ST_STAT: begin
          if (fall) begin
            sddat_oe  <= 1'b0;
            sddat_out <= 4'hF;
          end
          if (rise) begin
            if (bit_cnt == 3'd0) begin
              tmo_cnt <= tmo_cnt + TMO_W'(1);
              if (start_bit) bit_cnt <= 3'd1;
            end else begin
              if (bit_cnt <= 3'd3) stat_sh <= {stat_sh[1:0], sddat_in[0]};
              bit_cnt <= bit_cnt + 3'd1;
            end
          end
        end
        default: ;
      endcase

      if (state_d == ST_FIN && state != ST_FIN) begin
        wstat <= tmo_exit ? TIMEOUT : stat_sh;
        werr  <= tmo_exit || (stat_sh != ACCEPTED);
      end
    end
  end

endmodule

// File: tb/tb_sd_dat_writer.sv
// Self-checking bench for sd_dat_writer. Models the host byte source and
// an SD card; expected frames come from a polynomial-division CRC model.
// Define SD_DAT_WRITER_BUSY_TIMEOUT_EN to exercise the busy timeout.
module tb_sd_dat_writer;

  localparam int PRE    = 8;
  localparam int STAT_T = 64;
`ifdef SD_DAT_WRITER_BUSY_TIMEOUT_EN
  localparam int BUSY_T = 50;
`else
  localparam int BUSY_T = 1000000;
`endif
  localparam int END_J  = PRE + 1041;   // sdclk cycle carrying the end bit
  localparam int STS_J  = END_J + 3;    // card's status start bit (Ncrc = 2)

  logic       clk = 1'b0;
  logic       rst;
  logic       sdclk;
  logic [3:0] sddat_in;
  logic [3:0] sddat_out;
  logic       sddat_oe;
  logic       wstart;
  logic       wbusy, wdone, werr;
  logic [2:0] wstat;
  logic       inreq;
  logic [8:0] inaddr;
  logic [7:0] inbyte;
  logic [3:0] card_dat;

  // Pads: while we drive, the readback is our own value.
  assign sddat_in = sddat_oe ? sddat_out : card_dat;

  sd_dat_writer #(
    .PRE_CYCLES   (PRE),
    .STAT_TIMEOUT (STAT_T),
    .BUSY_TIMEOUT (BUSY_T)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .sdclk     (sdclk),
    .sddat_in  (sddat_in),
    .sddat_out (sddat_out),
    .sddat_oe  (sddat_oe),
    .wstart    (wstart),
    .wbusy     (wbusy),
    .wdone     (wdone),
    .werr      (werr),
    .wstat     (wstat),
    .inreq     (inreq),
    .inaddr    (inaddr),
    .inbyte    (inbyte)
  );

  int          n_vec = 0;
  int          n_err = 0;
  int          exp_addr = 0;
  logic [7:0]  mem [512];
  logic [15:0] mcrc [4];

  initial forever #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Byte source: answers a request with valid data for exactly one clk,
  // junk otherwise, and checks that addresses run 0..511 in order.
  initial begin
    logic       p;
    logic [8:0] a;
    inbyte = 8'h00;
    forever begin
      @(negedge clk);
      p = inreq;
      a = inaddr;
      if (p) begin
        check("inaddr", 32'(a), 32'(exp_addr));
        exp_addr++;
      end
      @(posedge clk);
      #1;
      inbyte = p ? mem[a] : 8'($urandom);
    end
  end

  // CRC as the remainder of m(x)*x^16 divided by x^16+x^12+x^5+1.
  function automatic logic [15:0] crc_model(input int line);
    bit         b [1040];
    logic [3:0] nb;
    logic [15:0] r;
    for (int i = 0; i < 1040; i++) b[i] = 1'b0;
    for (int i = 0; i < 1024; i++) begin
      nb   = (i % 2 == 0) ? mem[i / 2][7:4] : mem[i / 2][3:0];
      b[i] = nb[line];
    end
    for (int i = 0; i < 1024; i++) begin
      if (b[i]) begin
        b[i]      = ~b[i];
        b[i + 4]  = ~b[i + 4];
        b[i + 11] = ~b[i + 11];
        b[i + 16] = ~b[i + 16];
      end
    end
    for (int k = 0; k < 16; k++) r[15 - k] = b[1024 + k];
    return r;
  endfunction

  // {oe, dat} expected during sdclk cycle j of the transfer.
  function automatic logic [4:0] exp_frame(input int j);
    int n;
    if (j < PRE) return 5'h1F;
    if (j == PRE) return 5'h10;
    if (j <= PRE + 1024) begin
      n = j - PRE - 1;
      return {1'b1, (n % 2 == 0) ? mem[n / 2][7:4] : mem[n / 2][3:0]};
    end
    if (j <= PRE + 1040) begin
      n = 15 - (j - PRE - 1025);
      return {1'b1, mcrc[3][n], mcrc[2][n], mcrc[1][n], mcrc[0][n]};
    end
    if (j == END_J) return 5'h1F;
    return 5'h0F;
  endfunction

  function automatic logic card_d0(input int j, input logic [2:0] token,
                                   input int busy_cyc, input bit hold_high);
    if (hold_high) return 1'b1;
    if (j == STS_J) return 1'b0;
    if (j >= STS_J + 1 && j <= STS_J + 3) return token[STS_J + 3 - j];
    if (j >= STS_J + 5 && j <= STS_J + 4 + busy_cyc) return 1'b0;
    return 1'b1;
  endfunction

  task automatic run_sector(input string name, input int kind, input logic [2:0] token,
                            input int busy_cyc, input bit hold_high, input int glitch_at,
                            input int abort_at, input bit start_at_done);
    int         exp_pos, done_pos, max_j;
    logic [2:0] exp_stat;
    bit         done, aborted;
    for (int i = 0; i < 512; i++)
      mem[i] = (kind == 0) ? 8'h00 : (kind == 1) ? 8'(i) : 8'($urandom);
    for (int l = 0; l < 4; l++) mcrc[l] = crc_model(l);

    if (hold_high) begin
      // 64th rise spent in STAT, counting from the end-bit cycle.
      exp_pos  = (END_J + STAT_T - 1) * 4 + 2;
      exp_stat = 3'b111;
`ifdef SD_DAT_WRITER_BUSY_TIMEOUT_EN
    end else if (busy_cyc >= BUSY_T) begin
      exp_pos  = (STS_J + 4 + BUSY_T) * 4 + 2;
      exp_stat = 3'b111;
`endif
    end else begin
      exp_pos  = (STS_J + 5 + busy_cyc) * 4 + 2;
      exp_stat = token;
    end
    max_j    = exp_pos / 4 + 16;
    done     = 1'b0;
    aborted  = 1'b0;
    done_pos = -1;

    exp_addr = 0;
    wstart = 1'b1;
    tick();
    wstart = 1'b0;
    check({name, ".wbusy_start"}, 32'(wbusy), 32'd1);

    for (int j = 0; j < max_j && !done; j++) begin
      sdclk    = 1'b0;
      card_dat = {3'b111, card_d0(j, token, busy_cyc, hold_high)};
      if (j == glitch_at) wstart = 1'b1;
      for (int k = 0; k < 2 && !done; k++) begin
        tick();
        wstart = 1'b0;
        if (wdone) begin
          done     = 1'b1;
          done_pos = j * 4 + k;
        end
        if (k == 0) check({name, ".frame"}, 32'({sddat_oe, sddat_out}), 32'(exp_frame(j)));
        if (k == 0 && j == abort_at) begin
          rst = 1'b1;
          tick();
          rst = 1'b0;
          check({name, ".rst_oe"}, 32'(sddat_oe), 32'd0);
          check({name, ".rst_out"}, 32'(sddat_out), 32'hF);
          check({name, ".rst_wbusy"}, 32'(wbusy), 32'd0);
          check({name, ".rst_wdone"}, 32'(wdone), 32'd0);
          aborted = 1'b1;
          done    = 1'b1;
        end
      end
      if (!done) begin
        sdclk = 1'b1;
        for (int k = 0; k < 2 && !done; k++) begin
          tick();
          if (wdone) begin
            done     = 1'b1;
            done_pos = j * 4 + 2 + k;
          end
        end
      end
    end

    if (aborted) begin
      sdclk = 1'b1;
      repeat (6) tick();
      check({name, ".idle_after_rst"}, 32'({wbusy, inreq, sddat_oe}), 32'd0);
    end else if (!done) begin
      check({name, ".wdone_timeout"}, 32'd0, 32'd1);
    end else begin
      check({name, ".wdone_pos"}, 32'(done_pos), 32'(exp_pos));
      check({name, ".wstat"}, 32'(wstat), 32'(exp_stat));
      check({name, ".werr"}, 32'(werr), 32'(exp_stat != 3'b010));
      check({name, ".req_count"}, 32'(exp_addr), 32'd512);
      if (start_at_done) wstart = 1'b1;
      tick();
      wstart = 1'b0;
      check({name, ".wdone_pulse"}, 32'(wdone), 32'd0);
      check({name, ".wbusy_end"}, 32'(wbusy), 32'd0);
      check({name, ".no_restart"}, 32'(inreq), 32'd0);
      check({name, ".wstat_hold"}, 32'(wstat), 32'(exp_stat));
      sdclk = 1'b1;
      repeat (3) tick();
    end
  endtask

  initial begin
    rst      = 1'b1;
    sdclk    = 1'b1;
    wstart   = 1'b0;
    card_dat = 4'hF;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    check("reset.oe", 32'(sddat_oe), 32'd0);
    check("reset.out", 32'(sddat_out), 32'hF);
    check("reset.flags", 32'({wbusy, wdone, werr, inreq}), 32'd0);
    check("reset.wstat", 32'(wstat), 32'd0);
    check("reset.inaddr", 32'(inaddr), 32'd0);

    run_sector("zeros",    0, 3'b010,   5, 1'b0, -1,  -1, 1'b0);
    run_sector("ramp",     1, 3'b010,   3, 1'b0, -1,  -1, 1'b1);
    run_sector("crc_err",  2, 3'b101,   7, 1'b0, -1,  -1, 1'b0);
    run_sector("wr_err",   2, 3'b110,   2, 1'b0, -1,  -1, 1'b0);
    run_sector("stat_tmo", 2, 3'b010,   0, 1'b1, -1,  -1, 1'b0);
    run_sector("busy100",  2, 3'b010, 100, 1'b0, -1,  -1, 1'b0);
    run_sector("abort",    2, 3'b010,   4, 1'b0,  3, PRE + 1 + 300, 1'b0);
    run_sector("recover",  1, 3'b010,   1, 1'b0, -1,  -1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
